// File: rtl/ret_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack_pkg
// Description : Shared definitions for the return-address stack.
//               - Default PC width and stack depth for the datapath.
//               - Operation type for one clock edge.
//               - Decode function that maps push/pop requests and the
//                 current occupancy onto that operation type.
// Revision    : 1.0 - initial release
// ============================================================================
package ret_stack_pkg;

  // Default PC / return-address width and stack depth.
  localparam int DEF_AW    = 10;
  localparam int DEF_DEPTH = 16;

  // Operation resolved for one clock edge. The illegal cases get their own
  // codes so that the flag updates fall directly out of the decode.
  typedef enum logic [2:0] {
    OP_HOLD     = 3'd0,  // no request
    OP_PUSH     = 3'd1,  // push into a non-full stack
    OP_POP      = 3'd2,  // pop from a non-empty stack
    OP_REPLACE  = 3'd3,  // push+pop on a non-empty stack: overwrite the top
    OP_OVERFLOW = 3'd4,  // push on a full stack: value dropped
    OP_UNDERFLOW= 3'd5,  // pop on an empty stack: nothing to pop
    OP_PUSH_UNF = 3'd6   // push+pop on an empty stack: push, flag the pop
  } op_e;

  function automatic op_e decode_op(input logic push,
                                    input logic pop,
                                    input logic is_empty,
                                    input logic is_full);
    op_e op;
    op = OP_HOLD;
    if (push && pop) begin
      op = is_empty ? OP_PUSH_UNF : OP_REPLACE;
    end else if (push) begin
      op = is_full ? OP_OVERFLOW : OP_PUSH;
    end else if (pop) begin
      op = is_empty ? OP_UNDERFLOW : OP_POP;
    end
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ret_stack_mem.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack_mem
// Description : DEPTH x AW register file for the return-address stack.
//               One synchronous write port, one asynchronous read port.
//               Contents are not reset; the owner masks reads while empty.
// Ports       : clk     - clock, writes on rising edge
//               we      - write enable
//               wr_addr - write index
//               wr_data - write data
//               rd_addr - read index
//               rd_data - read data, combinational from rd_addr
// Revision    : 1.0 - initial release
// ============================================================================
module ret_stack_mem #(
  parameter int AW    = 10,
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wr_addr,
  input  logic [AW-1:0] wr_data,
  input  logic [IW-1:0] rd_addr,
  output logic [AW-1:0] rd_data
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack
// Description : Hardware return-address stack (LIFO). JAL pushes the return
//               PC; RET pops and the current top is presented on d_out in
//               the same cycle for the PC mux. Occupancy is tracked by a
//               saturating stack pointer; misuse sets sticky flags.
// Ports       : clk       - clock, all state on rising edge
//               reset     - synchronous active-low reset
//               push      - push request (control unit we_stack)
//               pop       - pop request (control unit s_jret)
//               d_in      - return address to push
//               d_out     - top of stack, 0 when empty
//               count     - valid entries, 0..DEPTH
//               empty     - count == 0
//               full      - count == DEPTH
//               overflow  - sticky: push attempted while full
//               underflow - sticky: pop attempted while empty
// Revision    : 1.0 - initial release
// ============================================================================
module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] d_in,
  output logic [AW-1:0] d_out,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  // Index width of the storage array; the extra bit of sp lets it reach DEPTH.
  localparam int            IW       = CW - 1;
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);

  logic [CW-1:0] sp;        // next free slot == number of valid entries
  logic          is_empty;
  logic          is_full;
  op_e           op;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_addr;
  logic          mem_we;
  logic [AW-1:0] rd_data;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == C_FULL);
  assign op       = decode_op(push, pop, is_empty, is_full);

  // When empty this wraps to the last slot; the read is masked below, so
  // stale or uninitialised storage never reaches d_out.
  assign top_idx  = IW'(sp - C_ONE);

  // Replace writes over the current top; every other write lands in the
  // next free slot (slot 0 for the push+pop-on-empty case).
  assign wr_addr  = (op == OP_REPLACE) ? top_idx : IW'(sp);

  // Reset takes priority: a write requested in a reset cycle is discarded.
  assign mem_we   = reset && ((op == OP_PUSH) ||
                              (op == OP_REPLACE) ||
                              (op == OP_PUSH_UNF));

  ret_stack_mem #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (wr_addr),
    .wr_data (d_in),
    .rd_addr (top_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (op)
        OP_PUSH:      sp        <= sp + C_ONE;
        OP_POP:       sp        <= sp - C_ONE;
        OP_OVERFLOW:  overflow  <= 1'b1;
        OP_UNDERFLOW: underflow <= 1'b1;
        OP_PUSH_UNF: begin
          sp        <= C_ONE;
          underflow <= 1'b1;
        end
        default: ;  // OP_HOLD, OP_REPLACE: sp and flags unchanged
      endcase
    end
  end

  assign d_out = is_empty ? '0 : rd_data;
  assign count = sp;
  assign empty = is_empty;
  assign full  = is_full;

endmodule
`default_nettype wire

// File: tb/tb_ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_ret_stack
// Description : Self-checking bench for ret_stack. A queue-based LIFO model
//               runs in lockstep with the DUT; table rows and hand-written
//               sequences are also checked against fixed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ret_stack;

  localparam int AW    = 10;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [AW-1:0] d_in = '0;
  logic [AW-1:0] d_out;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  ret_stack #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .d_in      (d_in),
    .d_out     (d_out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a plain queue whose back is the top of stack.
  int q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  typedef struct {
    bit            rst_n;
    bit            push;
    bit            pop;
    logic [AW-1:0] d;
    int            exp_count;
    logic [AW-1:0] exp_dout;
    bit            exp_ovf;
    bit            exp_unf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int model_top();
    return (q.size() == 0) ? 0 : q[$];
  endfunction

  task automatic model_step(input bit r, input bit p, input bit o, input int d);
    if (!r) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (p && o) begin
      if (q.size() == 0) begin
        q.push_back(d);
        m_unf = 1'b1;
      end else begin
        q[q.size()-1] = d;
      end
    end else if (p) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(d);
    end else if (o) begin
      if (q.size() == 0) m_unf = 1'b1;
      else void'(q.pop_back());
    end
  endtask

  // One clock: drive, check the top during a pop cycle, clock, update the
  // model and check every output against it.
  task automatic cycle(input bit r, input bit p, input bit o, input logic [AW-1:0] d);
    reset = r;
    push  = p;
    pop   = o;
    d_in  = d;
    @(negedge clk);
    if (r && o) chk("pop_cycle_dout", 32'(d_out), 32'(model_top()));
    @(posedge clk);
    #1;
    model_step(r, p, o, int'(d));
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_dout", 32'(d_out), 32'(model_top()));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_full", 32'(full), 32'(q.size() == DEPTH));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    chk("m_unf", 32'(underflow), 32'(m_unf));
  endtask

  task automatic expect_state(input string name, input int c, input int dv,
                              input bit ov, input bit un);
    chk({name, "_count"}, 32'(count), 32'(c));
    chk({name, "_dout"}, 32'(d_out), 32'(dv));
    chk({name, "_empty"}, 32'(empty), 32'(c == 0));
    chk({name, "_full"}, 32'(full), 32'(c == DEPTH));
    chk({name, "_ovf"}, 32'(overflow), 32'(ov));
    chk({name, "_unf"}, 32'(underflow), 32'(un));
  endtask

  vec_t tbl[17];

  initial begin
    // Directed table: push/pop order, underflow, push+pop on empty,
    // reset discarding a push, replace on a two-entry stack.
    tbl[0]  = '{1, 0, 0, 10'h000, 0, 10'h000, 0, 0};
    tbl[1]  = '{1, 1, 0, 10'h011, 1, 10'h011, 0, 0};
    tbl[2]  = '{1, 1, 0, 10'h022, 2, 10'h022, 0, 0};
    tbl[3]  = '{1, 1, 0, 10'h033, 3, 10'h033, 0, 0};
    tbl[4]  = '{1, 0, 1, 10'h000, 2, 10'h022, 0, 0};
    tbl[5]  = '{1, 0, 1, 10'h000, 1, 10'h011, 0, 0};
    tbl[6]  = '{1, 0, 1, 10'h000, 0, 10'h000, 0, 0};
    tbl[7]  = '{1, 0, 1, 10'h000, 0, 10'h000, 0, 1};
    tbl[8]  = '{1, 1, 0, 10'h005, 1, 10'h005, 0, 1};
    tbl[9]  = '{1, 0, 1, 10'h000, 0, 10'h000, 0, 1};
    tbl[10] = '{1, 1, 1, 10'h007, 1, 10'h007, 0, 1};
    tbl[11] = '{0, 1, 0, 10'h123, 0, 10'h000, 0, 0};
    tbl[12] = '{1, 1, 0, 10'h010, 1, 10'h010, 0, 0};
    tbl[13] = '{1, 1, 0, 10'h020, 2, 10'h020, 0, 0};
    tbl[14] = '{1, 1, 1, 10'h0AB, 2, 10'h0AB, 0, 0};
    tbl[15] = '{1, 0, 1, 10'h000, 1, 10'h010, 0, 0};
    tbl[16] = '{1, 0, 1, 10'h000, 0, 10'h000, 0, 0};

    // Reset held for two cycles, then idle.
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    expect_state("reset", 0, 0, 0, 0);

    begin
      logic [AW-1:0] prev_dout;
      prev_dout = '0;
      for (int i = 0; i < 17; i++) begin
        reset = tbl[i].rst_n;
        push  = tbl[i].push;
        pop   = tbl[i].pop;
        d_in  = tbl[i].d;
        @(negedge clk);
        if (tbl[i].rst_n && tbl[i].pop)
          chk($sformatf("tbl%0d_pre_dout", i), 32'(d_out), 32'(prev_dout));
        @(posedge clk);
        #1;
        model_step(tbl[i].rst_n, tbl[i].push, tbl[i].pop, int'(tbl[i].d));
        expect_state($sformatf("tbl%0d", i), tbl[i].exp_count,
                     int'(tbl[i].exp_dout), tbl[i].exp_ovf, tbl[i].exp_unf);
        prev_dout = tbl[i].exp_dout;
      end
    end

    // Fill to DEPTH, replace on the full stack (no overflow), then overflow.
    for (int i = 1; i <= DEPTH; i++) cycle(1, 1, 0, AW'(i));
    expect_state("filled", DEPTH, DEPTH, 0, 0);
    cycle(1, 1, 1, 10'h2AA);
    expect_state("full_replace", DEPTH, 10'h2AA, 0, 0);
    cycle(1, 1, 0, 10'h3FF);
    expect_state("overflow", DEPTH, 10'h2AA, 1, 0);
    for (int i = DEPTH; i >= 1; i--) begin
      reset = 1'b1; push = 1'b0; pop = 1'b1; d_in = '0;
      @(negedge clk);
      chk($sformatf("drain%0d_dout", i), 32'(d_out), (i == DEPTH) ? 32'h2AA : 32'(i));
      @(posedge clk);
      #1;
      model_step(1, 0, 1, 0);
    end
    expect_state("drained", 0, 0, 1, 0);

    // Reset with a push pending on a five-entry stack.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, AW'(10'h040 + i));
    expect_state("five", 5, 10'h044, 1, 0);
    cycle(0, 1, 0, 10'h123);
    expect_state("mid_reset", 0, 0, 0, 0);
    cycle(1, 0, 0, '0);
    expect_state("after_reset", 0, 0, 0, 0);

    // Randomised traffic with phases biased toward filling and draining.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bit r, p, o;
      bias = ((i / 150) % 2 == 0) ? 70 : 30;
      r = ($urandom_range(0, 299) != 0);
      p = ($urandom_range(0, 99) < bias);
      o = ($urandom_range(0, 99) < (100 - bias));
      cycle(r, p, o, AW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
